// File: rtl/data_cache_nway.sv
// N-way set-associative, write-through, no-write-allocate data cache with
// burst line refill, acknowledged byte-enabled write-through, stall and flush.
module data_cache_nway #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 256,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    write_en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  input  logic [DATA_WIDTH/8-1:0] byte_en_i,
  input  logic                    flush_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    stall_o,
  output logic                    hit_o,
  output logic                    mem_rd_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr_o,
  input  logic                    mem_rd_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data_i,
  output logic                    mem_wr_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wr_data_o,
  output logic [DATA_WIDTH/8-1:0] mem_wr_be_o,
  input  logic                    mem_wr_ack_i
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
  state_t state, state_next;

  logic [DATA_WIDTH-1:0] data_mem [NUM_WAYS][NUM_SETS][LINE_WORDS];
  logic [TAG_W-1:0]      tag_mem  [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0]   valid    [NUM_SETS];
  logic [WAY_W-1:0]      rr       [NUM_SETS];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  assign req_off = addr_i[OFF_W+1:2];
  assign req_idx = addr_i[OFF_W+2 +: IDX_W];
  assign req_tag = addr_i[ADDR_WIDTH-1 -: TAG_W];

  // Miss context, captured when the refill starts.
  logic [WAY_W-1:0] victim_way;
  logic             victim_rr;
  logic [IDX_W-1:0] line_idx;
  logic [TAG_W-1:0] line_tag;
  logic [OFF_W-1:0] beat_cnt;

  logic             hit, has_invalid;
  logic [WAY_W-1:0] hit_way, inv_way, victim_sel;

  // Descending scan so the lowest-index matching/invalid way wins.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[req_idx][w]) begin
        has_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
    end
  end

  assign victim_sel = has_invalid ? inv_way : rr[req_idx];

  logic refill_beat, last_beat, start_refill, do_flush;
  assign refill_beat = (state == REFILL) && mem_rd_valid_i;
  assign last_beat   = refill_beat && (beat_cnt == OFF_W'(LINE_WORDS - 1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    stall_o      = 1'b0;
    hit_o        = 1'b0;
    mem_rd_req_o = 1'b0;
    mem_wr_req_o = 1'b0;
    start_refill = 1'b0;
    do_flush     = 1'b0;
    case (state)
      IDLE: begin
        if (flush_i) begin
          stall_o  = 1'b1;
          do_flush = 1'b1;
        end else if (req_i) begin
          if (write_en_i) begin
            stall_o    = 1'b1;
            state_next = WRITE;
          end else if (hit) begin
            hit_o = 1'b1;
          end else begin
            stall_o      = 1'b1;
            start_refill = 1'b1;
            state_next   = REFILL;
          end
        end
      end
      REFILL: begin
        stall_o      = 1'b1;
        mem_rd_req_o = 1'b1;
        if (last_beat) state_next = IDLE;
      end
      WRITE: begin
        mem_wr_req_o = 1'b1;
        stall_o      = !mem_wr_ack_i;
        if (mem_wr_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign read_data_o   = data_mem[hit_way][req_idx][req_off];
  assign mem_rd_addr_o = {line_tag, line_idx, {(OFF_W + 2){1'b0}}};
  assign mem_wr_addr_o = addr_i & ~ADDR_WIDTH'(3);
  assign mem_wr_data_o = write_data_i;
  assign mem_wr_be_o   = byte_en_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_next;
      if (start_refill)     beat_cnt <= '0;
      else if (refill_beat) beat_cnt <= beat_cnt + OFF_W'(1);
    end

    if (rst_i || do_flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      // Victim stays invalid until its last beat, so an aborted refill never exposes a partial line.
      if (start_refill) valid[req_idx][victim_sel] <= 1'b0;
      if (last_beat) begin
        valid[line_idx][victim_way] <= 1'b1;
        if (victim_rr)
          rr[line_idx] <= (NUM_WAYS == 1) ? '0 : rr[line_idx] + WAY_W'(1);
      end
    end
  end

  // NOTE: tag/data arrays and miss context carry no reset; valid bits alone decide what is live.
  always_ff @(posedge clk_i) begin
    if (start_refill) begin
      victim_way <= victim_sel;
      victim_rr  <= !has_invalid;
      line_idx   <= req_idx;
      line_tag   <= req_tag;
    end
    if (!rst_i && refill_beat) begin
      data_mem[victim_way][line_idx][beat_cnt] <= mem_rd_data_i;
      if (last_beat) tag_mem[victim_way][line_idx] <= line_tag;
    end
    if (!rst_i && state == WRITE && mem_wr_ack_i && hit) begin
      for (int b = 0; b < BE_W; b++)
        if (byte_en_i[b])
          data_mem[hit_way][req_idx][req_off][8*b +: 8] <= write_data_i[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_cache_nway.sv
// Randomized and directed bench for data_cache_nway against a line-level
// cache model plus a flat main-memory model.
module tb_data_cache_nway;
  localparam int AW = 32, DW = 32, SETS = 256, WAYS = 2, LW = 4;
  localparam int LINE_BYTES = LW * (DW / 8);

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            rst_i, req_i, write_en_i, flush_i;
  logic [AW-1:0]   addr_i;
  logic [DW-1:0]   write_data_i, read_data_o, mem_rd_data_i, mem_wr_data_o;
  logic [DW/8-1:0] byte_en_i, mem_wr_be_o;
  logic            stall_o, hit_o, mem_rd_req_o, mem_rd_valid_i, mem_wr_req_o, mem_wr_ack_i;
  logic [AW-1:0]   mem_rd_addr_o, mem_wr_addr_o;

  data_cache_nway #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SETS(SETS),
                    .NUM_WAYS(WAYS), .LINE_WORDS(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_en_i(write_en_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .byte_en_i(byte_en_i),
    .flush_i(flush_i), .read_data_o(read_data_o), .stall_o(stall_o), .hit_o(hit_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_data_i(mem_rd_data_i),
    .mem_wr_req_o(mem_wr_req_o), .mem_wr_addr_o(mem_wr_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_wr_be_o(mem_wr_be_o), .mem_wr_ack_i(mem_wr_ack_i)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Main memory: untouched words read back as an address-derived pattern.
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] mem_word(input int unsigned a);
    int unsigned wa;
    wa = a & ~32'd3;
    if (mem.exists(wa)) return mem[wa];
    return wa ^ 32'h5EED_0000;
  endfunction

  // Cache model: which line lives in each way. Write-through keeps every
  // cached word equal to memory, so data comes from the memory model.
  int unsigned m_line  [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  int          m_rr    [SETS];

  function automatic int set_of(input int unsigned a);
    return int'((a / LINE_BYTES) % SETS);
  endfunction
  function automatic int unsigned line_of(input int unsigned a);
    return a - (a % LINE_BYTES);
  endfunction
  function automatic int m_find(input int unsigned a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set_of(a)][w] && m_line[set_of(a)][w] == line_of(a)) return w;
    return -1;
  endfunction
  function automatic void m_fill(input int unsigned a);
    int s, v;
    s = set_of(a);
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_line[s][v]  = line_of(a);
    m_valid[s][v] = 1'b1;
  endfunction
  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  task automatic drive_quiet();
    req_i = 1'b0; flush_i = 1'b0; mem_rd_valid_i = 1'b0; mem_wr_ack_i = 1'b0;
  endtask

  task automatic do_idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      drive_quiet();
      #1;
      check("idle_stall", stall_o, 0);
      check("idle_hit", hit_o, 0);
      check("idle_rd_req", mem_rd_req_o, 0);
      check("idle_wr_req", mem_wr_req_o, 0);
    end
  endtask

  // Load with an optional random gap between beats and an optional flush pulse mid-refill.
  task automatic do_load(input int unsigned a, input bit gaps, input bit flush_mid,
                         output logic [31:0] data, output int stalls);
    bit exp_hit, done, seen_hit;
    int cyc, beats, rd_cyc;
    exp_hit = (m_find(a) >= 0);
    done = 0; cyc = 0; beats = 0; rd_cyc = 0; stalls = 0; seen_hit = 0; data = 'x;
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      drive_quiet();
      req_i = 1'b1; write_en_i = 1'b0; addr_i = a;
      #1;
      if (mem_rd_req_o) begin
        if (rd_cyc == 0) check("rd_addr", mem_rd_addr_o, line_of(a));
        if (beats >= LW) check("rd_req_after_last", mem_rd_req_o, 0);
        if (mem_wr_req_o) check("wr_req_in_refill", mem_wr_req_o, 0);
        rd_cyc++;
        if (flush_mid && rd_cyc == 2) flush_i = 1'b1;
        if (!gaps || $urandom_range(0, 2) != 0) begin
          mem_rd_valid_i = 1'b1;
          mem_rd_data_i  = mem_word(line_of(a) + beats * 4);
          beats++;
        end
      end
      if (stall_o) stalls++;
      else begin
        done = 1; seen_hit = hit_o; data = read_data_o;
      end
      cyc++;
    end
    if (!done) check("load_timeout", stall_o, 0);
    check("load_hit_o", seen_hit, 1);
    if (exp_hit) check("load_hit_stalls", stalls, 0);
    else begin
      check("refill_beats", beats, LW);
      check("miss_stalls", stalls, gaps ? rd_cyc + 1 : LW + 1);
      m_fill(a);
    end
    check("load_data", data, mem_word(a));
  endtask

  task automatic do_store(input int unsigned a, input logic [31:0] d, input logic [3:0] be,
                          input int ack_dly, output int stalls);
    bit done;
    int cyc, wr_cyc;
    logic [31:0] old, merged;
    done = 0; cyc = 0; wr_cyc = 0; stalls = 0;
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      drive_quiet();
      req_i = 1'b1; write_en_i = 1'b1; addr_i = a; write_data_i = d; byte_en_i = be;
      #1;
      if (mem_rd_req_o) check("rd_req_on_store", mem_rd_req_o, 0);
      if (mem_wr_req_o) begin
        wr_cyc++;
        if (wr_cyc == 1) begin
          check("wr_addr", mem_wr_addr_o, a & ~32'd3);
          check("wr_data", mem_wr_data_o, d);
          check("wr_be", mem_wr_be_o, be);
        end
        if (wr_cyc == ack_dly) begin
          mem_wr_ack_i = 1'b1;
          #1;
        end
      end
      if (stall_o) stalls++;
      else done = 1;
      cyc++;
    end
    if (!done) check("store_timeout", stall_o, 0);
    check("store_stalls", stalls, ack_dly);
    check("wr_req_cycles", wr_cyc, ack_dly);
    old = mem_word(a);
    for (int b = 0; b < 4; b++) merged[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
    mem[a & ~32'd3] = merged;
  endtask

  task automatic do_flush(input bit with_req);
    @(negedge clk_i);
    drive_quiet();
    flush_i = 1'b1; req_i = with_req; write_en_i = 1'b0;
    #1;
    check("flush_stall", stall_o, 1);
    check("flush_hit", hit_o, 0);
    check("flush_rd_req", mem_rd_req_o, 0);
    m_clear();
    @(negedge clk_i);
    drive_quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int st, beats, cyc, op, w;
    int unsigned a;
    int unsigned tags [4] = '{32'h1, 32'h2, 32'h3, 32'h5};
    int unsigned sets [3] = '{0, 1, 255};

    drive_quiet();
    rst_i = 1'b1; write_en_i = 1'b0; addr_i = '0; write_data_i = '0; byte_en_i = '0;
    mem_rd_data_i = '0;
    for (int i = 0; i < 4; i++) mem[32'h1000 + 4 * i] = 32'hA0 + i;
    m_clear();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_hit", hit_o, 0);
    check("rst_rd_req", mem_rd_req_o, 0);
    check("rst_wr_req", mem_wr_req_o, 0);

    // Cold load, then a hit in the same line.
    do_load(32'h1004, 0, 0, d, st);
    check("cold_data", d, 32'hA1);
    check("cold_stall_cycles", st, 5);
    do_load(32'h100C, 0, 0, d, st);
    check("line_hit_data", d, 32'hA3);
    check("line_hit_stall", st, 0);

    // Store hit with a 3-cycle stall, then the merged word reads back.
    do_store(32'h1004, 32'h0000_5500, 4'b0010, 3, st);
    check("store_hit_stall", st, 3);
    do_load(32'h1004, 0, 0, d, st);
    check("merged_data", d, 32'h0000_55A1);
    check("merged_stall", st, 0);

    // Flush (with a request pending) forces the line to miss again.
    do_flush(1);
    do_load(32'h1004, 0, 0, d, st);
    check("post_flush_stall", st, 5);

    // Conflict eviction in set 0.
    do_flush(0);
    do_load(32'h1000, 0, 0, d, st); check("conf_1000_miss", st, 5);
    do_load(32'h2000, 0, 0, d, st); check("conf_2000_miss", st, 5);
    do_load(32'h3000, 0, 0, d, st); check("conf_3000_miss", st, 5);
    do_load(32'h2000, 0, 0, d, st); check("conf_2000_hit", st, 0);
    do_load(32'h1000, 0, 0, d, st); check("conf_1000_remiss", st, 5);
    do_load(32'h3000, 0, 0, d, st); check("conf_3000_kept", st, 0);
    do_load(32'h2000, 0, 0, d, st); check("conf_2000_evicted", st, 5);

    // Store miss: one write, no allocation.
    do_store(32'h8000, 32'hDEAD_BEEF, 4'hF, 1, st);
    do_idle(2);
    do_load(32'h8000, 0, 0, d, st);
    check("store_miss_refill", st, 5);
    check("store_miss_data", d, 32'hDEAD_BEEF);

    // Flush pulse during a refill is ignored.
    do_load(32'h5040, 0, 1, d, st);
    do_load(32'h2000, 0, 0, d, st);
    check("flush_in_refill_ignored", st, 0);

    // Reset after the second refill beat.
    do_flush(0);
    beats = 0; cyc = 0;
    while (beats < 2 && cyc < 50) begin
      @(negedge clk_i);
      drive_quiet();
      req_i = 1'b1; write_en_i = 1'b0; addr_i = 32'h1004;
      #1;
      if (mem_rd_req_o) begin
        mem_rd_valid_i = 1'b1;
        mem_rd_data_i  = mem_word(32'h1000 + beats * 4);
        beats++;
      end
      cyc++;
    end
    check("pre_reset_beats", beats, 2);
    @(negedge clk_i);
    drive_quiet();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("abort_stall", stall_o, 0);
    check("abort_rd_req", mem_rd_req_o, 0);
    check("abort_wr_req", mem_wr_req_o, 0);
    check("abort_hit", hit_o, 0);
    m_clear();
    do_load(32'h1004, 0, 0, d, st);
    check("abort_reload_stall", st, 5);

    // Randomized mix against the model.
    for (int i = 0; i < 300; i++) begin
      w  = $urandom_range(0, LW - 1);
      a  = (tags[$urandom_range(0, 3)] << 12) | (sets[$urandom_range(0, 2)] << 4) | (w << 2);
      op = $urandom_range(0, 99);
      if (op < 60)      do_load(a, $urandom_range(0, 1) == 1, 0, d, st);
      else if (op < 85) do_store(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(1, 4), st);
      else if (op < 90) do_flush($urandom_range(0, 1) == 1);
      else              do_idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/data_cache_nway.md
Name: data_cache_nway

Overview:
- Parametrised N-way set-associative, write-through, no-write-allocate data cache with multi-word lines.
- Sits between the CPU memory stage and main memory.
- Relative to the previous single-word cache, adds: configurable ways, sets and line size; burst line refill over a valid handshake; acknowledged write-through with byte enables; a CPU stall output; a flush.
- Lines are refilled in full on a read miss.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width. Must be a multiple of 8.
- NUM_SETS, 256, sets per way. Power of 2, ≥2.
- NUM_WAYS, 2, associativity. Power of 2, 1..8.
- LINE_WORDS, 4, words per line. Power of 2, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- req_i  in  1  CPU access valid. Must be held stable with addr/data/be while stall_o=1.
- write_en_i  in  1  1=store, 0=load.
- addr_i  in  ADDR_WIDTH  byte address. Bits [1:0] ignored.
- write_data_i  in  DATA_WIDTH  store data.
- byte_en_i  in  DATA_WIDTH/8  store byte enables.
- flush_i  in  1  invalidate entire cache.
- read_data_o  out  DATA_WIDTH  load data. Valid when req_i & !write_en_i & !stall_o.
- stall_o  out  1  CPU must hold the request.
- hit_o  out  1  1-cycle pulse on a completed load hit.
- mem_rd_req_o  out  1  line refill request.
- mem_rd_addr_o  out  ADDR_WIDTH  line-aligned refill address.
- mem_rd_valid_i  in  1  refill beat valid.
- mem_rd_data_i  in  DATA_WIDTH  refill beat data. Words arrive in order 0..LINE_WORDS-1.
- mem_wr_req_o  out  1  write-through request.
- mem_wr_addr_o  out  ADDR_WIDTH  word-aligned write address.
- mem_wr_data_o  out  DATA_WIDTH  write data.
- mem_wr_be_o  out  DATA_WIDTH/8  write byte enables.
- mem_wr_ack_i  in  1  write accepted.

Behaviour:
- Address split:
  - offset = addr[$clog2(LINE_WORDS)+1:2]
  - index = next $clog2(NUM_SETS) bits
  - tag = remaining upper bits
- Per set and way: valid, tag, and LINE_WORDS data words.
- Per set: round-robin pointer rr of width $clog2(NUM_WAYS), 0 when NUM_WAYS=1.
- FSM states: IDLE, REFILL, WRITE.
- IDLE + req_i + load + hit:
  - read_data_o = cached word, combinational.
  - stall_o=0, hit_o=1.
  - Replacement state is unchanged.
- IDLE + req_i + load + miss:
  - stall_o=1 in that cycle.
  - Latch the victim way and the line address.
  - Victim = lowest-index invalid way, else rr[index].
  - Clear the victim's valid bit. Go to REFILL.
- REFILL:
  - mem_rd_req_o=1 throughout; mem_rd_addr_o = line-aligned address.
  - Each cycle with mem_rd_valid_i, write the beat into word beat_cnt and increment beat_cnt.
  - On the last beat: set tag and valid. If the victim came from rr, set rr = rr+1 mod NUM_WAYS. Go to IDLE.
  - stall_o=1 in all REFILL cycles.
  - The held request then hits in IDLE.
  - With zero-wait memory, stall_o is high for exactly LINE_WORDS+1 cycles.
- IDLE + req_i + store: stall_o=1 that cycle; go to WRITE.
- WRITE:
  - mem_wr_req_o=1; mem_wr_addr/data/be driven from the CPU inputs.
  - stall_o = !mem_wr_ack_i.
  - On the ack cycle: if hit, merge the enabled bytes into the cached word. Then go to IDLE.
  - A store miss never allocates.
- mem_*_req_o is 0 outside REFILL/WRITE. Address and data outputs are don't-care when the request is low.
- flush_i:
  - Honoured only in IDLE; takes priority over req_i that cycle (stall_o=1).
  - Clears all valid bits and rr pointers at the edge.
  - Ignored in REFILL/WRITE; it must be held by the requester until honoured.
- IDLE with !req_i: stall_o=0, hit_o=0.
- Reset, at any time including mid-refill or mid-write:
  - Next state IDLE.
  - All valid=0, rr=0, beat_cnt=0.
  - stall_o=0, hit_o=0, mem_rd_req_o=0, mem_wr_req_o=0.
  - An aborted refill leaves the line invalid.
  - Data and tag arrays are not reset.

Test Plan (NUM_SETS=256, NUM_WAYS=2, LINE_WORDS=4, zero-wait memory unless stated):
- Cold load of 0x0000_1004:
  - mem_rd_addr_o=0x0000_1000; beats 0xA0,0xA1,0xA2,0xA3.
  - stall_o high 5 cycles, then read_data_o=0xA1, hit_o=1.
  - Load of 0x0000_100C then hits with 0xA3 and no stall.
- Conflict eviction in set 0:
  - Load 0x1000, then 0x2000, then 0x3000 (all miss). 0x3000 evicts the way holding 0x1000.
  - Load 0x2000 hits. Load 0x1000 misses and evicts 0x2000 (rr).
- Store hit:
  - After the first scenario, store 0x1004 data 0x0000_5500 be=0b0010; ack 3 cycles after mem_wr_req_o.
  - stall_o high 3 cycles; mem_wr_be_o=0b0010.
  - Next load of 0x1004 returns 0x0000_55A1.
- Store miss to 0x8000:
  - A single write transaction occurs.
  - A following load of 0x8000 misses and refills.
- flush_i in IDLE after the first scenario: load 0x1004 misses again.
  - flush_i asserted during REFILL is ignored until IDLE.
- rst_i after the 2nd refill beat:
  - Next cycle: all requests low, stall_o=0.
  - Re-issued load of 0x1004 misses with a full 4-beat refill.
